// File: rtl/seg_rx_pkg.sv
// Shared types and constants for the 7-segment scan receiver: FSM states,
// active-low segment patterns for hex digits, and one-hot digit strobes.
package seg_rx_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SETTLE,
    CAPTURE,
    WAIT
  } state_t;

  // Active-low patterns, bit order dp,g,f,e,d,c,b,a
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hA7;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [2:0] DIG_NONE = 3'b000;
  localparam logic [2:0] DIG_0    = 3'b100;
  localparam logic [2:0] DIG_1    = 3'b010;
  localparam logic [2:0] DIG_2    = 3'b001;

  function automatic logic [2:0] dig_for_idx(input logic [1:0] idx);
    case (idx)
      2'd0:    return DIG_0;
      2'd1:    return DIG_1;
      default: return DIG_2;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational 7-segment pattern decoder: active-low pattern to {ok, nibble}.
// Any pattern outside the hex table (including a lit dp) reports ok=0.
module seg_pattern_dec
  import seg_rx_pkg::*;
(
  input  logic [7:0] seg,
  output logic       ok,
  output logic [3:0] nibble
);

  always_comb begin
    ok     = 1'b1;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: ok     = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_rx.sv
// Receive monitor for a 3-digit multiplexed 7-segment bus: settles, decodes and
// reassembles 12-bit frames. Define SEG_RX_CONFIRM_EN to publish only repeated frames.
module seg_scan_rx
  import seg_rx_pkg::*;
#(
  parameter int SETTLE_CYC = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  seg_in,
  input  logic [2:0]  dig_in,
  output logic [11:0] value,
  output logic        value_valid,
  input  logic        value_ready,
  input  logic        err_clr,
  output logic        err_pattern,
  output logic        err_seq,
  output logic        err_overrun
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(SETTLE_CYC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_DONE) ? c : c + CNT_W'(1);
  endfunction

  logic [7:0]       seg_p0, seg_s, seg_prev;
  logic [2:0]       dig_p0, dig_s, dig_prev;
  state_t           state, state_nxt;
  logic [1:0]       idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             dec_ok;
  logic [3:0]       dec_nib;
  logic [3:0]       slot0, slot1;
  logic [11:0]      frame;
  logic             redirect, seq_evt, pat_evt, slot_we, frame_done, publish, ovr_evt;
  logic             dig_chg, seg_chg;
  logic [2:0]       dig_exp;

  // Stage p0/s: two-flop synchronizers, plus a one-cycle history for change detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_p0   <= SEG_BLANK;
      seg_s    <= SEG_BLANK;
      seg_prev <= SEG_BLANK;
      dig_p0   <= DIG_NONE;
      dig_s    <= DIG_NONE;
      dig_prev <= DIG_NONE;
    end else begin
      seg_p0   <= seg_in;
      seg_s    <= seg_p0;
      seg_prev <= seg_s;
      dig_p0   <= dig_in;
      dig_s    <= dig_p0;
      dig_prev <= dig_s;
    end
  end

  seg_pattern_dec u_dec (
    .seg    (seg_s),
    .ok     (dec_ok),
    .nibble (dec_nib)
  );

  assign dig_chg = (dig_s != dig_prev);
  assign seg_chg = (seg_s != seg_prev);
  assign dig_exp = dig_for_idx(idx);
  assign cnt_inc = sat_inc(cnt);
  assign frame   = {dec_nib, slot1, slot0};

  // Stage fsm: scan tracking, settle counting and capture
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= HUNT;
      idx   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    redirect   = 1'b0;
    seq_evt    = 1'b0;
    pat_evt    = 1'b0;
    slot_we    = 1'b0;
    frame_done = 1'b0;
    case (state)
      HUNT: begin
        if (dig_s == DIG_0) begin
          idx_nxt   = 2'd0;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (dig_chg) begin
          if (dig_s == DIG_NONE) state_nxt = WAIT;
          else                   redirect  = 1'b1;
        end else if (seg_chg) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CNT_DONE) state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!dec_ok) begin
          pat_evt   = 1'b1;
          idx_nxt   = 2'd0;
          state_nxt = HUNT;
        end else begin
          slot_we = 1'b1;
          if (idx == 2'd2) begin
            frame_done = 1'b1;
            idx_nxt    = 2'd0;
          end else begin
            idx_nxt = idx + 2'd1;
          end
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dig_chg && (dig_s != DIG_NONE)) redirect = 1'b1;
      end
      default: state_nxt = HUNT;
    endcase

    // A new non-blank strobe: expected digit, frame restart, or sequence break
    if (redirect) begin
      cnt_nxt = '0;
      if (dig_s == dig_exp) begin
        state_nxt = SETTLE;
      end else if (dig_s == DIG_0) begin
        seq_evt   = 1'b1;
        idx_nxt   = 2'd0;
        state_nxt = SETTLE;
      end else begin
        seq_evt   = 1'b1;
        idx_nxt   = 2'd0;
        state_nxt = HUNT;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (slot_we && (idx == 2'd0)) slot0 <= dec_nib;
    if (slot_we && (idx == 2'd1)) slot1 <= dec_nib;
  end

`ifdef SEG_RX_CONFIRM_EN
  logic [11:0] ref_frame;
  logic        ref_vld;
  logic        err_evt;

  assign err_evt = pat_evt | seq_evt | ovr_evt;
  assign publish = frame_done && ref_vld && (frame == ref_frame);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ref_vld <= 1'b0;
    end else if (err_evt) begin
      ref_vld <= 1'b0;
    end else if (frame_done && !publish) begin
      ref_vld <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (frame_done && !publish) ref_frame <= frame;
  end
`else
  assign publish = frame_done;
`endif

  // A frame arriving while the previous one is still pending is dropped, even on a handshake cycle
  assign ovr_evt = publish && value_valid;

  // Stage out: publish register, handshake and sticky flags
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      value       <= 12'h000;
      value_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_seq     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (value_valid && value_ready) value_valid <= 1'b0;
      if (publish && !value_valid) begin
        value       <= frame;
        value_valid <= 1'b1;
      end
      err_pattern <= pat_evt | (err_pattern & ~err_clr);
      err_seq     <= seq_evt | (err_seq & ~err_clr);
      err_overrun <= ovr_evt | (err_overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_seg_scan_rx.sv
// Self-checking bench for seg_scan_rx (default build): directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_seg_scan_rx;

  localparam int SETTLE_CYC = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  seg_in;
  logic [2:0]  dig_in;
  logic [11:0] value;
  logic        value_valid;
  logic        value_ready;
  logic        err_clr;
  logic        err_pattern;
  logic        err_seq;
  logic        err_overrun;

  int          tests = 0;
  int          fails = 0;
  int          pubs = 0;
  int          vv_cycles = 0;
  logic        vv_last = 1'b0;
  logic [11:0] last_pub = 12'h000;
  int          p0, vv0, lat, hold, gap;
  logic [11:0] v, exp_v, model_val;
  logic [7:0]  s [3];
  logic [4:0]  d;
  logic        all_ok;

  logic [7:0] enc_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};

  seg_scan_rx #(.SETTLE_CYC(SETTLE_CYC)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .seg_in      (seg_in),
    .dig_in      (dig_in),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .err_clr     (err_clr),
    .err_pattern (err_pattern),
    .err_seq     (err_seq),
    .err_overrun (err_overrun)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [4:0] model_dec(input logic [7:0] pat);
    for (int i = 0; i < 16; i++)
      if (enc_tab[i] == pat) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
    if (value_valid) vv_cycles++;
    if (value_valid && !vv_last) begin
      pubs++;
      last_pub = value;
    end
    vv_last = value_valid;
  endtask

  task automatic show(input logic [2:0] dg, input logic [7:0] sg, input int n);
    dig_in = dg;
    seg_in = sg;
    repeat (n) tick();
  endtask

  task automatic blank(input int n);
    show(3'b000, 8'hFF, n);
  endtask

  task automatic send(input logic [11:0] fv, input int hl);
    show(3'b100, enc_tab[fv[3:0]], hl);
    show(3'b010, enc_tab[fv[7:4]], hl);
    show(3'b001, enc_tab[fv[11:8]], hl);
    blank(4);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    seg_in      = 8'hFF;
    dig_in      = 3'b000;
    value_ready = 1'b0;
    err_clr     = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_value", value, 12'h000);
    check("rst_valid", value_valid, 1'b0);
    check("rst_err_pattern", err_pattern, 1'b0);
    check("rst_err_seq", err_seq, 1'b0);
    check("rst_err_overrun", err_overrun, 1'b0);
    sys_rst_n   = 1'b1;
    value_ready = 1'b1;
    blank(4);

    // Clean frame
    p0 = pubs; vv0 = vv_cycles;
    send(12'h3A5, 64);
    check("t1_pubs", pubs - p0, 1);
    check("t1_value", last_pub, 12'h3A5);
    check("t1_valid_cycles", vv_cycles - vv0, 1);
    check("t1_valid_after", value_valid, 1'b0);
    check("t1_err_pattern", err_pattern, 1'b0);
    check("t1_err_seq", err_seq, 1'b0);
    check("t1_err_overrun", err_overrun, 1'b0);

    // Lit dp on digit 1
    p0 = pubs;
    show(3'b100, enc_tab[5], 64);
    show(3'b010, 8'h7F, 64);
    show(3'b001, enc_tab[3], 64);
    blank(4);
    check("t2_err_pattern", err_pattern, 1'b1);
    check("t2_no_pub", pubs - p0, 0);
    p0 = pubs;
    send(12'h3A5, 64);
    check("t2_next_pub", pubs - p0, 1);
    check("t2_next_value", last_pub, 12'h3A5);
    pulse_clr();
    check("t2_clr", err_pattern, 1'b0);

    // Strobe order 100 then 001
    p0 = pubs;
    show(3'b100, enc_tab[5], 64);
    show(3'b001, enc_tab[3], 64);
    blank(4);
    check("t3_err_seq", err_seq, 1'b1);
    check("t3_no_pub", pubs - p0, 0);
    pulse_clr();
    check("t3_clr", err_seq, 1'b0);

    // Overrun with consumer stalled
    value_ready = 1'b0;
    p0 = pubs;
    send(12'h3A5, 64);
    send(12'h111, 64);
    check("t4_value_held", value, 12'h3A5);
    check("t4_valid", value_valid, 1'b1);
    check("t4_err_overrun", err_overrun, 1'b1);
    check("t4_pubs", pubs - p0, 1);
    value_ready = 1'b1;
    tick();
    check("t4_valid_drop", value_valid, 1'b0);
    pulse_clr();
    check("t4_clr", err_overrun, 1'b0);

    // Segment toggles mid-settle restart the count
    p0 = pubs;
    show(3'b100, enc_tab[5], 10);
    show(3'b100, enc_tab[6], 64);
    show(3'b010, enc_tab[10], 64);
    show(3'b001, enc_tab[3], 10);
    seg_in = enc_tab[4];
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (value_valid && lat == 0) lat = i;
    end
    check("t5_latency", lat, SETTLE_CYC + 4);
    check("t5_value", last_pub, 12'h4A6);

    // Digit shown too briefly, then a frame restart at idx 2
    p0 = pubs;
    show(3'b100, enc_tab[7], 64);
    show(3'b010, enc_tab[12], 64);
    show(3'b001, enc_tab[0], 12);
    blank(30);
    check("t5_short_no_pub", pubs - p0, 0);
    check("t5_short_no_err", err_seq, 1'b0);
    send(12'h2C4, 64);
    check("t5_restart_pub", pubs - p0, 1);
    check("t5_restart_value", last_pub, 12'h2C4);
    check("t5_restart_err_seq", err_seq, 1'b1);

    // Reset mid-frame
    show(3'b100, enc_tab[7], 64);
    show(3'b010, enc_tab[12], 64);
    sys_rst_n = 1'b0;
    #1;
    check("t6_rst_value", value, 12'h000);
    check("t6_rst_err_seq", err_seq, 1'b0);
    check("t6_rst_valid", value_valid, 1'b0);
    dig_in = 3'b001;
    seg_in = enc_tab[0];
    repeat (3) tick();
    sys_rst_n = 1'b1;
    p0 = pubs;
    show(3'b001, enc_tab[0], 64);
    blank(4);
    check("t6_partial_dropped", pubs - p0, 0);
    send(12'h0C7, 64);
    check("t6_pub", pubs - p0, 1);
    check("t6_value", value, 12'h0C7);
    model_val = 12'h0C7;

    // Randomized frames, occasionally corrupting digit 1 or 2
    for (int f = 0; f < 10; f++) begin
      v    = 12'($urandom_range(0, 4095));
      s[0] = enc_tab[v[3:0]];
      s[1] = enc_tab[v[7:4]];
      s[2] = enc_tab[v[11:8]];
      if ($urandom_range(0, 2) == 0) s[$urandom_range(1, 2)] = 8'($urandom_range(0, 255));
      hold = $urandom_range(SETTLE_CYC + 8, 40);
      gap  = $urandom_range(0, 3);
      all_ok = 1'b1;
      exp_v  = 12'h000;
      for (int k = 0; k < 3; k++) begin
        d = model_dec(s[k]);
        if (!d[4]) all_ok = 1'b0;
        exp_v[k*4 +: 4] = d[3:0];
      end
      p0 = pubs;
      show(3'b100, s[0], hold);
      blank(gap);
      show(3'b010, s[1], hold);
      blank(gap);
      show(3'b001, s[2], hold);
      blank(4);
      if (all_ok) model_val = exp_v;
      check("rnd_pubs", pubs - p0, {31'd0, all_ok});
      check("rnd_value", value, model_val);
      check("rnd_err_pattern", err_pattern, !all_ok);
      check("rnd_err_seq", err_seq, 1'b0);
      pulse_clr();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
